// File: rtl/dmem_responder_if.sv
// CPU MEM-stage data-memory bus.
// The CPU (master) drives the request fields and holds them until Ready_o.
// The responder (slave) returns read data, the completion pulse, the
// pipeline stall and the sticky address-error flag.
interface dmem_responder_if;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic [31:0] Address_i;
  logic [31:0] Writedata_i;
  logic [31:0] Readdata_o;
  logic        Ready_o;
  logic        Stall_o;
  logic        AddrErr_o;

  modport master (
    output MemRead_i, MemWrite_i, Address_i, Writedata_i,
    input  Readdata_o, Ready_o, Stall_o, AddrErr_o
  );

  modport slave (
    input  MemRead_i, MemWrite_i, Address_i, Writedata_i,
    output Readdata_o, Ready_o, Stall_o, AddrErr_o
  );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the CPU MEM stage.
// Each request is captured in IDLE, waits LATENCY cycles and completes with
// a one-cycle Ready_o pulse; Stall_o freezes the pipeline meanwhile.
// The array access (write and read-before-write data) happens on the edge
// that enters RESP. Misaligned or out-of-range addresses suppress the write,
// return zero and set the sticky AddrErr_o flag.
// Optional feature: define DMEM_STATS_EN to add saturating RdCount_o and
// WrCount_o counters of completed non-error reads and writes.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  dmem_responder_if.slave    bus
`ifdef DMEM_STATS_EN
  ,
  output logic [15:0]        RdCount_o,
  output logic [15:0]        WrCount_o
`endif
);

  localparam int ADDR_W = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t state;
  state_t state_next;

  logic [3:0]        count;
  logic              cap_write;
  logic              cap_err;
  logic [ADDR_W-1:0] cap_index;
  logic [31:0]       cap_data;

  logic [31:0]       readdata;
  logic              addr_err;

  logic [31:0]       mem [DEPTH_WORDS];

  logic              req;
  logic              live_err;
  logic [ADDR_W-1:0] live_index;
  logic              enter_resp;
  logic              acc_write;
  logic              acc_err;
  logic [ADDR_W-1:0] acc_index;
  logic [31:0]       acc_data;

  // Decode the live request: word index and address-error condition.
  always_comb begin
    req        = bus.MemRead_i | bus.MemWrite_i;
    live_index = bus.Address_i[ADDR_W+1:2];
    live_err   = (bus.Address_i[1:0] != 2'b00) ||
                 ((bus.Address_i >> (ADDR_W + 2)) != 32'd0);
  end

  // Next-state logic; with zero latency IDLE jumps straight to RESP.
  always_comb begin
    state_next = state;
    enter_resp = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          if (LATENCY == 0) begin
            state_next = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (count == 4'd0) begin
          state_next = ST_RESP;
          enter_resp = 1'b1;
        end
      end
      ST_RESP: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Access operands: live inputs when the access happens straight out of
  // IDLE (zero latency), otherwise the values captured at request time.
  always_comb begin
    acc_write = cap_write;
    acc_err   = cap_err;
    acc_index = cap_index;
    acc_data  = cap_data;
    if (state == ST_IDLE) begin
      acc_write = bus.MemWrite_i;
      acc_err   = live_err;
      acc_index = live_index;
      acc_data  = bus.Writedata_i;
    end
  end

  // State register, wait counter and request capture.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= ST_IDLE;
      count     <= 4'd0;
      cap_write <= 1'b0;
      cap_err   <= 1'b0;
      cap_index <= '0;
      cap_data  <= 32'd0;
    end else begin
      state <= state_next;
      if (state == ST_IDLE && req) begin
        count     <= LAT_INIT;
        cap_write <= bus.MemWrite_i;
        cap_err   <= live_err;
        cap_index <= live_index;
        cap_data  <= bus.Writedata_i;
      end else if (state == ST_WAIT && count != 4'd0) begin
        count <= count - 4'd1;
      end
    end
  end

  // Response data (read-before-write) and sticky error flag, updated on the
  // edge that enters RESP.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      readdata <= 32'd0;
      addr_err <= 1'b0;
    end else if (enter_resp) begin
      if (acc_err) begin
        readdata <= 32'd0;
        addr_err <= 1'b1;
      end else begin
        readdata <= mem[acc_index];
      end
    end
  end

  // Array write; not reset, and gated by reset so a request held during
  // reset can never modify the contents.
  always_ff @(posedge clk_i) begin
    if (rst_i && enter_resp && acc_write && !acc_err) begin
      mem[acc_index] <= acc_data;
    end
  end

`ifdef DMEM_STATS_EN
  // Saturating counters of completed non-error reads and writes.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      RdCount_o <= 16'd0;
      WrCount_o <= 16'd0;
    end else if (enter_resp && !acc_err) begin
      if (acc_write) begin
        if (WrCount_o != 16'hFFFF) WrCount_o <= WrCount_o + 16'd1;
      end else begin
        if (RdCount_o != 16'hFFFF) RdCount_o <= RdCount_o + 16'd1;
      end
    end
  end
`endif

  // Bus outputs: stall while a request is pending, ready only in RESP.
  always_comb begin
    bus.Readdata_o = readdata;
    bus.AddrErr_o  = addr_err;
    bus.Ready_o    = (state == ST_RESP);
    bus.Stall_o    = ((state == ST_IDLE) && req) || (state == ST_WAIT);
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed testbench for dmem_responder: one LATENCY=2 instance for the
// main scenarios and one LATENCY=0 instance for the zero-wait path.
module tb_dmem_responder;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  dmem_responder_if bus();
  dmem_responder_if bus0();

`ifdef DMEM_STATS_EN
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;
  logic [15:0] rd_cnt0;
  logic [15:0] wr_cnt0;
`endif

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus.slave)
`ifdef DMEM_STATS_EN
    ,
    .RdCount_o (rd_cnt),
    .WrCount_o (wr_cnt)
`endif
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) dut0 (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus0.slave)
`ifdef DMEM_STATS_EN
    ,
    .RdCount_o (rd_cnt0),
    .WrCount_o (wr_cnt0)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request on the LATENCY=2 bus starting just after a negedge,
  // hold it until Ready_o, drop it, and record per-cycle observations.
  task automatic run_req(input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] data,
                         output logic [11:0] stall_h, output logic [11:0] ready_h,
                         output logic [11:0] err_h, output logic [31:0] rdata,
                         output int rcyc);
    stall_h = '0;
    ready_h = '0;
    err_h   = '0;
    rdata   = 32'd0;
    rcyc    = -1;
    bus.MemRead_i   = rd;
    bus.MemWrite_i  = wr;
    bus.Address_i   = addr;
    bus.Writedata_i = data;
    for (int c = 0; c < 12; c++) begin
      #1;
      stall_h[c] = bus.Stall_o;
      ready_h[c] = bus.Ready_o;
      err_h[c]   = bus.AddrErr_o;
      if (bus.Ready_o && rcyc < 0) begin
        rcyc  = c;
        rdata = bus.Readdata_o;
      end
      @(negedge clk);
      if (rcyc >= 0) begin
        bus.MemRead_i  = 1'b0;
        bus.MemWrite_i = 1'b0;
      end
      if (rcyc >= 0 && c >= rcyc + 1) break;
    end
    bus.MemRead_i  = 1'b0;
    bus.MemWrite_i = 1'b0;
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if (bus.Readdata_o !== 32'd0 || bus.Ready_o !== 1'b0 ||
        bus.Stall_o !== 1'b0 || bus.AddrErr_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: rd=%h rdy=%b stall=%b err=%b required 0", bus.Readdata_o, bus.Ready_o, bus.Stall_o, bus.AddrErr_o);
    end
    total++;
    if (bus0.Ready_o !== 1'b0 || bus0.Stall_o !== 1'b0 || bus0.AddrErr_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_outputs_lat0: rdy=%b stall=%b err=%b required 0", bus0.Ready_o, bus0.Stall_o, bus0.AddrErr_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    logic [11:0] st, rdy, er;
    logic [31:0] rd;
    int rc;
    run_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, st, rdy, er, rd, rc);
    total++;
    if (rc !== 3 || st[4:0] !== 5'b00111 || rdy[4:0] !== 5'b01000) begin
      bad++;
      $display("[TB] FAIL write_timing: ready_cycle=%0d stall=%b ready=%b required 3 00111 01000", rc, st[4:0], rdy[4:0]);
    end
    run_req(1'b1, 1'b0, 32'h10, 32'h0, st, rdy, er, rd, rc);
    total++;
    if (rc !== 3 || st[4:0] !== 5'b00111 || rdy[4:0] !== 5'b01000) begin
      bad++;
      $display("[TB] FAIL read_timing: ready_cycle=%0d stall=%b ready=%b required 3 00111 01000", rc, st[4:0], rdy[4:0]);
    end
    total++;
    if (rd !== 32'hDEADBEEF) begin
      bad++;
      $display("[TB] FAIL read_data: got %h required DEADBEEF", rd);
    end
  endtask

  task automatic test_misaligned();
    logic [11:0] st, rdy, er;
    logic [31:0] rd;
    int rc;
    run_req(1'b0, 1'b1, 32'h13, 32'h12345678, st, rdy, er, rd, rc);
    total++;
    if (rc !== 3 || er[4:0] !== 5'b11000) begin
      bad++;
      $display("[TB] FAIL misaligned_err: ready_cycle=%0d err=%b required 3 11000", rc, er[4:0]);
    end
    total++;
    if (rd !== 32'd0) begin
      bad++;
      $display("[TB] FAIL misaligned_rdata: got %h required 0", rd);
    end
    run_req(1'b1, 1'b0, 32'h10, 32'h0, st, rdy, er, rd, rc);
    total++;
    if (rd !== 32'hDEADBEEF || er[rc] !== 1'b1) begin
      bad++;
      $display("[TB] FAIL misaligned_no_write: data=%h err=%b required DEADBEEF 1", rd, er[3]);
    end
  endtask

  task automatic test_out_of_range();
    logic [11:0] st, rdy, er;
    logic [31:0] rd;
    int rc;
    applyReset();
    total++;
    if (bus.AddrErr_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL err_cleared_before: got %b required 0", bus.AddrErr_o);
    end
    run_req(1'b1, 1'b0, 32'h400, 32'h0, st, rdy, er, rd, rc);
    total++;
    if (rc !== 3 || rd !== 32'd0 || er[3] !== 1'b1) begin
      bad++;
      $display("[TB] FAIL out_of_range: ready_cycle=%0d data=%h err=%b required 3 0 1", rc, rd, er[3]);
    end
    applyReset();
    total++;
    if (bus.AddrErr_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL err_cleared_after: got %b required 0", bus.AddrErr_o);
    end
  endtask

  task automatic test_read_write_both();
    logic [11:0] st, rdy, er;
    logic [31:0] rd;
    int rc;
    run_req(1'b0, 1'b1, 32'h20, 32'h1, st, rdy, er, rd, rc);
    run_req(1'b1, 1'b1, 32'h20, 32'h2, st, rdy, er, rd, rc);
    total++;
    if (rc !== 3 || rd !== 32'h1) begin
      bad++;
      $display("[TB] FAIL both_prior_data: ready_cycle=%0d data=%h required 3 00000001", rc, rd);
    end
    run_req(1'b1, 1'b0, 32'h20, 32'h0, st, rdy, er, rd, rc);
    total++;
    if (rd !== 32'h2) begin
      bad++;
      $display("[TB] FAIL both_written: got %h required 00000002", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] st, rdy;
    bus.MemRead_i  = 1'b1;
    bus.MemWrite_i = 1'b0;
    bus.Address_i  = 32'h10;
    for (int c = 0; c < 8; c++) begin
      #1;
      st[c]  = bus.Stall_o;
      rdy[c] = bus.Ready_o;
      @(negedge clk);
    end
    bus.MemRead_i = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if (st[7:0] !== 8'b0111_0111 || rdy[7:0] !== 8'b1000_1000) begin
      bad++;
      $display("[TB] FAIL back_to_back: stall=%b ready=%b required 01110111 10001000", st[7:0], rdy[7:0]);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [11:0] st, rdy, er;
    logic [31:0] rd;
    int rc;
    logic seen;
    run_req(1'b0, 1'b1, 32'h30, 32'hCAFEF00D, st, rdy, er, rd, rc);
    bus.MemWrite_i  = 1'b1;
    bus.Address_i   = 32'h30;
    bus.Writedata_i = 32'hAAAA5555;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    bus.MemWrite_i = 1'b0;
    #1;
    total++;
    if (bus.Readdata_o !== 32'd0 || bus.Ready_o !== 1'b0 || bus.Stall_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_mid_wait_outputs: rd=%h rdy=%b stall=%b required 0", bus.Readdata_o, bus.Ready_o, bus.Stall_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (bus.Ready_o) seen = 1'b1;
      @(negedge clk);
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_mid_wait_ready: pulse seen=%b required 0", seen);
    end
    run_req(1'b1, 1'b0, 32'h30, 32'h0, st, rdy, er, rd, rc);
    total++;
    if (rd !== 32'hCAFEF00D) begin
      bad++;
      $display("[TB] FAIL reset_mid_wait_mem: got %h required CAFEF00D", rd);
    end
  endtask

  task automatic test_latency0();
    bus0.MemWrite_i  = 1'b1;
    bus0.MemRead_i   = 1'b0;
    bus0.Address_i   = 32'h8;
    bus0.Writedata_i = 32'h00C0FFEE;
    @(negedge clk);
    bus0.MemWrite_i  = 1'b0;
    @(negedge clk);
    bus0.MemRead_i   = 1'b1;
    #1;
    total++;
    if (bus0.Stall_o !== 1'b1 || bus0.Ready_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL lat0_cycle0: stall=%b ready=%b required 1 0", bus0.Stall_o, bus0.Ready_o);
    end
`ifdef DMEM_STATS_EN
    total++;
    if (rd_cnt0 !== 16'd0 || wr_cnt0 !== 16'd1) begin
      bad++;
      $display("[TB] FAIL lat0_counts_before: rd=%0d wr=%0d required 0 1", rd_cnt0, wr_cnt0);
    end
`endif
    @(negedge clk);
    bus0.MemRead_i = 1'b0;
    #1;
    total++;
    if (bus0.Stall_o !== 1'b0 || bus0.Ready_o !== 1'b1 || bus0.Readdata_o !== 32'h00C0FFEE) begin
      bad++;
      $display("[TB] FAIL lat0_cycle1: stall=%b ready=%b data=%h required 0 1 00C0FFEE", bus0.Stall_o, bus0.Ready_o, bus0.Readdata_o);
    end
`ifdef DMEM_STATS_EN
    total++;
    if (rd_cnt0 !== 16'd1) begin
      bad++;
      $display("[TB] FAIL lat0_rdcount: got %0d required 1", rd_cnt0);
    end
`endif
    @(negedge clk);
    #1;
    total++;
    if (bus0.Ready_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL lat0_pulse_width: ready=%b required 0", bus0.Ready_o);
    end
  endtask

  // Test sequence and summary.
  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.MemRead_i    = 1'b0;
    bus.MemWrite_i   = 1'b0;
    bus.Address_i    = 32'd0;
    bus.Writedata_i  = 32'd0;
    bus0.MemRead_i   = 1'b0;
    bus0.MemWrite_i  = 1'b0;
    bus0.Address_i   = 32'd0;
    bus0.Writedata_i = 32'd0;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_misaligned();
    test_out_of_range();
    test_read_write_both();
    test_back_to_back();
    test_reset_mid_wait();
    test_latency0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #20000;
    $display("[TB] FAIL timeout: simulation exceeded 20000 time units");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder on the far side of the CPU MEM-stage interface.
- The CPU drives MemRead/MemWrite, Address and Writedata; this block serves each request after a configurable number of wait states.
- It holds the pipeline with Stall_o until the access completes, then returns read data with a one-cycle Ready_o pulse.
- Replaces the single-cycle combinational data memory so the pipeline can be exercised against realistic memory latency.

Parameters:
- DEPTH_WORDS, 256: number of 32-bit words; power of two, at least 4.
- LATENCY, 2: wait-state cycles between request capture and response; 0 to 15.
- ADDR_W, log2(DEPTH_WORDS): derived word-index width; not overridden.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- MemRead_i  in  1  read request; held by CPU until Ready_o.
- MemWrite_i  in  1  write request; held by CPU until Ready_o.
- Address_i  in  32  byte address.
- Writedata_i  in  32  write data.
- Readdata_o  out  32  read data; valid while Ready_o=1, held otherwise.
- Ready_o  out  1  one-cycle completion pulse.
- Stall_o  out  1  freeze request to the pipeline (PC, IF/ID, ID/EX, EX/MEM hold).
- AddrErr_o  out  1  sticky address-error flag.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - State goes to IDLE; Readdata_o=0, Ready_o=0, Stall_o=0, AddrErr_o=0; wait counter=0.
  - Memory array contents are not cleared.
- State machine: IDLE, WAIT, RESP.
  - IDLE: on an edge with req=(MemRead_i|MemWrite_i)=1, capture op, word index and write data. Go to WAIT with counter=LATENCY-1, or straight to RESP if LATENCY=0.
  - WAIT: counter decrements each edge; at 0 the next edge enters RESP.
  - RESP: Ready_o=1 for exactly one cycle. Next edge always returns to IDLE.
  - Inputs seen during WAIT and RESP are ignored; the captured values are used.
- Access timing: the array write and the Readdata_o update happen on the edge that enters RESP.
  - Read: Readdata_o = mem[index].
  - Write: mem[index] <= data, and Readdata_o = prior word content (read-before-write).
- Stall_o is combinational: 1 when (IDLE and req) or in WAIT; 0 in RESP. The pipeline therefore advances at the end of the RESP cycle.
- Total occupancy per request is LATENCY+2 cycles, IDLE sample through RESP.
- Back-to-back requests: a new request is sampled in the IDLE cycle after RESP; there is no overlap.
- MemRead_i and MemWrite_i both 1: treated as a write; Readdata_o returns the pre-write word.
- Address error: Address_i[1:0]!=0, or any of Address_i[31:ADDR_W+2] nonzero.
  - The response is still produced with normal timing and Ready_o.
  - Write is suppressed; Readdata_o=0.
  - AddrErr_o is set on the RESP-entry edge and stays 1 until reset.
- Word index = Address_i[ADDR_W+1:2]; there is no wrap-around, because out-of-range accesses are errors.
- Reset mid-WAIT: the pending write is dropped (array unchanged) and no Ready_o pulse is produced.

Optional Feature:
- Macro: DMEM_STATS_EN.
- When defined, two extra outputs are added:
  - RdCount_o[15:0]: counts completed non-error reads (Ready_o pulses).
  - WrCount_o[15:0]: counts completed non-error writes (Ready_o pulses).
  - Both saturate at 0xFFFF and reset to 0.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- LATENCY=2, write 0xDEADBEEF to 0x10, request at cycle 0 -> Stall_o=1 cycles 0-2, Ready_o=1 cycle 3 only, Stall_o=0 cycle 3. Read of 0x10 next -> Readdata_o=0xDEADBEEF with Ready_o, same timing.
- Write 0x12345678 to 0x13 (misaligned) -> Ready_o at cycle 3, AddrErr_o=1 from cycle 3 onward. Read of 0x10 afterward -> 0xDEADBEEF, AddrErr_o still 1.
- DEPTH_WORDS=256, read 0x400 (out of range) -> Readdata_o=0 with Ready_o, AddrErr_o=1. Reset -> AddrErr_o=0.
- MemRead_i=MemWrite_i=1, address 0x20 holding 0x1, Writedata_i=0x2 -> Readdata_o=0x1 at Ready_o. Subsequent read of 0x20 -> 0x2.
- Write 0xAAAA5555 to 0x30, rst_i low during WAIT cycle 1 -> outputs 0 immediately, no Ready_o pulse. Read of 0x30 -> prior contents unchanged.
- LATENCY=0, read -> Stall_o=1 cycle 0, Ready_o=1 cycle 1. With DMEM_STATS_EN defined, RdCount_o increments by 1 on the Ready_o edge.
